decode_ctrl_pipe: RTL and testbench

Registered, handshaked successor to the combinational control decoder in the Mini-RISC-V decode stage. It accepts one 32-bit instruction per cycle over valid/ready, decodes it into a packed control word, and holds the result in an output register until the execute stage takes it. It adds the behaviour the combinational decoder lacks: an `rd==x0` write-enable kill, bubble handling for the all-zero word, flush/hazard-aware issue gating, and an optional M-extension with a structural-hazard counter for the non-pipelined divider.

---
 rtl/ctrl_pkg.sv | 98 +++++++++
 rtl/ctrl_decode.sv | 144 ++++++++++++++
 rtl/decode_ctrl_pipe.sv | 72 +++++++
 tb/tb_decode_ctrl_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types, opcode constants and small decode helpers for the decode control pipe.
package ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [3:0] CMP_LT  = 4'b0001;
  localparam logic [3:0] CMP_LTU = 4'b0010;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR  = 4'd3,
    ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7
  } alusel_e;

  // br is one-hot: [0]=beq [1]=bne [2]=blt [3]=bge [4]=bltu [5]=bgeu.
  // loadcntrl one-hot lb,lh,lw,lbu,lhu from bit 0; storecntrl one-hot sb,sh,sw.
  typedef struct packed {
    logic [3:0] alusel;
    logic [2:0] storecntrl;
    logic [4:0] loadcntrl;
    logic [3:0] cmpcntrl;
    logic [5:0] br;
    logic       branch;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       alusrc;
    logic       compare;
    logic       auipc;
    logic       lui;
    logic       jal;
    logic       jalr;
    logic [2:0] csrsel;
    logic       csrread;
    logic       csrwrite;
    logic       md;
    logic [2:0] mdop;
    logic       illegal;
  } ctrl_t;

  // alt selects SUB for funct3 000 and SRA for funct3 101.
  function automatic alusel_e alu_op(input logic [2:0] f3, input logic alt);
    alusel_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SUB;
      3'b011:  op = ALU_SUB;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [3:0] cmp_ctrl(input logic [2:0] f3);
    logic [3:0] c;
    case (f3)
      3'b010:  c = CMP_LT;
      3'b011:  c = CMP_LTU;
      default: c = 4'b0000;
    endcase
    return c;
  endfunction

  // Implemented machine CSRs; any other address selects 0.
  function automatic logic [2:0] csr_sel(input logic [11:0] addr);
    logic [2:0] s;
    case (addr)
      12'h300: s = 3'd1;
      12'h304: s = 3'd2;
      12'h305: s = 3'd3;
      12'h341: s = 3'd4;
      12'h342: s = 3'd5;
      12'h344: s = 3'd6;
      default: s = 3'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32I (+ optional M, macro M_EXT_EN) decoder from instruction word to ctrl_t.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] ins,
  output ctrl_t       ctrl
);

  logic [6:0] opc;
  logic [6:0] f7;
  logic [2:0] f3;
  logic [4:0] rd;
  logic [4:0] rs1;
  ctrl_t      c;
  logic       ill;

  assign opc = ins[6:0];
  assign rd  = ins[11:7];
  assign f3  = ins[14:12];
  assign rs1 = ins[19:15];
  assign f7  = ins[31:25];

  // Per-opcode field decode; ill marks any encoding not recognised here.
  always_comb begin
    c   = '0;
    ill = 1'b0;
    case (opc)
      OPC_LUI: begin
        c.lui = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        c.auipc = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
      end
      OPC_JAL: begin
        c.jal = 1'b1; c.regwrite = 1'b1;
      end
      OPC_JALR: begin
        c.jalr = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        if (f3 != 3'b000) ill = 1'b1;
        else              ill = 1'b0;
      end
      OPC_BRANCH: begin
        c.branch = 1'b1;
        c.alusel = ALU_SUB;
        case (f3)
          3'b000:  c.br = 6'b000001;
          3'b001:  c.br = 6'b000010;
          3'b100:  c.br = 6'b000100;
          3'b101:  c.br = 6'b001000;
          3'b110:  c.br = 6'b010000;
          3'b111:  c.br = 6'b100000;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        c.memread = 1'b1; c.alusrc = 1'b1; c.regwrite = 1'b1;
        case (f3)
          3'b000:  c.loadcntrl = 5'b00001;
          3'b001:  c.loadcntrl = 5'b00010;
          3'b010:  c.loadcntrl = 5'b00100;
          3'b100:  c.loadcntrl = 5'b01000;
          3'b101:  c.loadcntrl = 5'b10000;
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        c.memwrite = 1'b1; c.alusrc = 1'b1;
        case (f3)
          3'b000:  c.storecntrl = 3'b001;
          3'b001:  c.storecntrl = 3'b010;
          3'b010:  c.storecntrl = 3'b100;
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.alusel   = alu_op(f3, (f3 == 3'b101) && (f7 == 7'b0100000));
        c.compare  = (f3 == 3'b010) || (f3 == 3'b011);
        c.cmpcntrl = cmp_ctrl(f3);
        if ((f3 == 3'b001) && (f7 != 7'b0000000))
          ill = 1'b1;
        else if ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000))
          ill = 1'b1;
        else
          ill = 1'b0;
      end
      OPC_OP: begin
        c.regwrite = 1'b1;
        case (f7)
          7'b0000000: begin
            c.alusel   = alu_op(f3, 1'b0);
            c.compare  = (f3 == 3'b010) || (f3 == 3'b011);
            c.cmpcntrl = cmp_ctrl(f3);
          end
          7'b0100000: begin
            c.alusel = alu_op(f3, 1'b1);
            if ((f3 != 3'b000) && (f3 != 3'b101)) ill = 1'b1;
            else                                  ill = 1'b0;
          end
`ifdef M_EXT_EN
          7'b0000001: begin
            c.md     = 1'b1;
            c.mdop   = f3;
            c.alusel = {1'b1, f3};
          end
`endif
          default: ill = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        c.regwrite = 1'b1;
        c.alusrc   = f3[2];
        c.csrsel   = csr_sel(ins[31:20]);
        case (f3)
          F3_CSRRW, F3_CSRRWI: begin
            c.csrread  = (rd != 5'd0);
            c.csrwrite = 1'b1;
          end
          F3_CSRRS, F3_CSRRC, F3_CSRRSI, F3_CSRRCI: begin
            c.csrread  = 1'b1;
            c.csrwrite = (rs1 != 5'd0);
          end
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  end

  // Bubble and illegal words collapse to fixed words; rd==x0 never writes.
  always_comb begin
    ctrl = c;
    if (ins == 32'h0000_0000) begin
      ctrl = '0;
    end else if (ill) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end else begin
      ctrl.regwrite = c.regwrite && (rd != 5'd0);
    end
  end

endmodule

// File: rtl/decode_ctrl_pipe.sv
// Handshaked, registered decode stage. Optional M extension and divider
// occupancy counter are enabled by defining M_EXT_EN.
module decode_ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 32,
  parameter int XLEN       = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_ins,
  input  logic            flush,
  input  logic            hazard,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           out_ctrl,
  output logic [XLEN-1:0] out_ins,
  output logic            div_busy
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  ctrl_t         dec;
  logic          acc;
  logic [CW-1:0] div_cnt;

  ctrl_decode u_decode (
    .ins  (in_ins),
    .ctrl (dec)
  );

  assign in_ready = !rst && !hazard && !div_busy && (!out_valid || out_ready);
  assign acc      = in_valid && in_ready;
  assign div_busy = (div_cnt != {CW{1'b0}});

  // Output register: flush beats accept, otherwise a taken word drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_ins   <= {XLEN{1'b0}};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_ctrl  <= dec;
      out_ins   <= in_ins;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef M_EXT_EN
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  // Divider occupancy: only the divide class (mdop[2]) holds the unit.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      div_cnt <= {CW{1'b0}};
    end else if (acc && dec.md && dec.mdop[2]) begin
      div_cnt <= DIV_LOAD;
    end else if (div_busy) begin
      div_cnt <= div_cnt - CW'(1);
    end
  end
`else
  assign div_cnt = {CW{1'b0}};
`endif

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized self-checking bench for decode_ctrl_pipe against a behavioural model.
module tb_decode_ctrl_pipe;
  import ctrl_pkg::*;

  localparam int DIVC = 4;
`ifdef M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, hazard, out_valid, out_ready, div_busy;
  logic [31:0] in_ins, out_ins;
  ctrl_t       out_ctrl;

  int checks = 0;
  int failures = 0;

  // behavioural model state
  bit          m_valid;
  logic [31:0] m_ins;
  ctrl_t       m_ctrl;
  int          cyc = 0;
  int          busy_until = 0;

  decode_ctrl_pipe #(.DIV_CYCLES(DIVC), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins),
    .flush(flush), .hazard(hazard), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_ins(out_ins), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_div(input logic [31:0] w);
    return M_EN && (w[6:0] == 7'h33) && (w[31:25] == 7'h01) && w[14];
  endfunction

  // Reference decode written from the instruction-set rules, table style.
  function automatic ctrl_t ref_decode(input logic [31:0] w);
    ctrl_t c;
    int alu_tab [8];
    logic [11:0] csr_tab [6];
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1;
    bit ok, wr, alt;
    int f;
    alu_tab = '{0, 5, 1, 1, 4, 6, 3, 2};
    csr_tab = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344};
    c = '0; ok = 1'b1; wr = 1'b0;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25]; rd = w[11:7]; rs1 = w[19:15];
    f = int'(f3);
    if (w == 32'd0) return c;
    if (op == 7'h37) begin c.lui = 1; c.alusrc = 1; wr = 1; end
    else if (op == 7'h17) begin c.auipc = 1; c.alusrc = 1; wr = 1; end
    else if (op == 7'h6f) begin c.jal = 1; wr = 1; end
    else if (op == 7'h67 && f == 0) begin c.jalr = 1; c.alusrc = 1; wr = 1; end
    else if (op == 7'h63 && f != 2 && f != 3) begin
      c.branch = 1; c.alusel = 4'd1;
      c.br = 6'(1 << ((f < 2) ? f : f - 2));
    end
    else if (op == 7'h03 && (f < 3 || f == 4 || f == 5)) begin
      c.memread = 1; c.alusrc = 1; wr = 1;
      c.loadcntrl = 5'(1 << ((f < 4) ? f : f - 1));
    end
    else if (op == 7'h23 && f < 3) begin
      c.memwrite = 1; c.alusrc = 1; c.storecntrl = 3'(1 << f);
    end
    else if ((op == 7'h13 && (f == 1 ? f7 == 0 : (f == 5 ? (f7 == 0 || f7 == 7'h20) : 1'b1))) ||
             (op == 7'h33 && (f7 == 0 || (f7 == 7'h20 && (f == 0 || f == 5))))) begin
      alt = (f7 == 7'h20) && (op == 7'h33 || f == 5);
      c.alusel = 4'(alu_tab[f] + ((alt && (f == 0 || f == 5)) ? 1 : 0));
      c.alusrc = (op == 7'h13);
      c.compare = (f == 2 || f == 3);
      c.cmpcntrl = (f == 2) ? 4'd1 : ((f == 3) ? 4'd2 : 4'd0);
      wr = 1;
    end
    else if (M_EN && op == 7'h33 && f7 == 7'h01) begin
      c.md = 1; c.mdop = f3; c.alusel = 4'(8 + f); wr = 1;
    end
    else if (op == 7'h73 && f != 0 && f != 4) begin
      wr = 1; c.alusrc = (f >= 4);
      for (int i = 0; i < 6; i++) if (csr_tab[i] == w[31:20]) c.csrsel = 3'(i + 1);
      c.csrread  = (f % 4 != 1) || (rd != 0);
      c.csrwrite = (f % 4 == 1) || (rs1 != 0);
    end
    else ok = 1'b0;
    if (!ok) begin c = '0; c.illegal = 1'b1; return c; end
    c.regwrite = wr && (rd != 0);
    return c;
  endfunction

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_ins = 32'h00500093;
    flush = 1'b0; hazard = 1'b0; out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    repeat (2) @(posedge clk);
    cyc += 2;
    #1;
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    check_eq("rst_out_ins", 64'(out_ins), 64'd0);
    check_eq("rst_div_busy", 64'(div_busy), 64'd0);
    m_valid = 1'b0; m_ins = 32'd0; m_ctrl = '0; busy_until = 0;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  // One clock: drive, check in_ready, advance the model, check registered outputs.
  task automatic drive_cycle(input logic v, input logic [31:0] ins, input logic fl,
                             input logic hz, input logic ordy, output logic acc);
    bit m_ready, m_acc;
    in_valid = v; in_ins = ins; flush = fl; hazard = hz; out_ready = ordy;
    #1;
    m_ready = !hz && !(cyc < busy_until) && (!m_valid || ordy);
    check_eq("in_ready", 64'(in_ready), 64'(m_ready));
    acc = v && in_ready;
    m_acc = v && m_ready;
    @(posedge clk);
    cyc++;
    if (fl) begin
      m_valid = 1'b0; busy_until = 0;
    end else if (m_acc) begin
      m_valid = 1'b1; m_ins = ins; m_ctrl = ref_decode(ins);
      if (is_div(ins)) busy_until = cyc + DIVC - 1;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    #1;
    check_eq("out_valid", 64'(out_valid), 64'(m_valid));
    check_eq("div_busy", 64'(div_busy), 64'(cyc < busy_until));
    if (m_valid) begin
      check_eq("out_ins", 64'(out_ins), 64'(m_ins));
      check_eq("out_ctrl", 64'(out_ctrl), 64'(m_ctrl));
    end
  endtask

  function automatic logic [31:0] gen_ins();
    logic [31:0] w;
    logic [6:0] ops [9];
    logic [11:0] csrs [4];
    int sel;
    ops  = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h73};
    csrs = '{12'h300, 12'h305, 12'h344, 12'h7c0};
    w = $urandom;
    sel = $urandom_range(0, 11);
    case (sel)
      0:       w = 32'd0;
      1, 2:    w = $urandom;
      default: w[6:0] = ops[$urandom_range(0, 8)];
    endcase
    case ($urandom_range(0, 3))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      2:       w[31:25] = 7'h01;
      default: w[31:25] = w[31:25];
    endcase
    if (w[6:0] == 7'h73 && $urandom_range(0, 1) == 1) w[31:20] = csrs[$urandom_range(0, 3)];
    if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
    if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
    return w;
  endfunction

  initial begin
    logic acc;
    int stalls;
    do_reset();

    drive_cycle(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b1, acc);
    check_eq("addi_valid", 64'(out_valid), 64'd1);
    check_eq("addi_alusrc", 64'(out_ctrl.alusrc), 64'd1);
    check_eq("addi_regwrite", 64'(out_ctrl.regwrite), 64'd1);
    check_eq("addi_alusel", 64'(out_ctrl.alusel), 64'd0);
    check_eq("addi_illegal", 64'(out_ctrl.illegal), 64'd0);

    drive_cycle(1'b1, 32'h00000033, 1'b0, 1'b0, 1'b1, acc);
    check_eq("add_x0_regwrite", 64'(out_ctrl.regwrite), 64'd0);
    drive_cycle(1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1, acc);
    check_eq("zero_valid", 64'(out_valid), 64'd1);
    check_eq("zero_ctrl", 64'(out_ctrl), 64'd0);

    drive_cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, acc);
    check_eq("ffff_illegal", 64'(out_ctrl.illegal), 64'd1);
    check_eq("ffff_enables", 64'({out_ctrl.memwrite, out_ctrl.regwrite, out_ctrl.branch}), 64'd0);

    drive_cycle(1'b1, 32'h30029073, 1'b0, 1'b0, 1'b1, acc);
    check_eq("csrrw_wr_rd_rw", 64'({out_ctrl.csrwrite, out_ctrl.csrread, out_ctrl.regwrite}), 64'b100);
    check_eq("csrrw_csrsel", 64'(out_ctrl.csrsel), 64'd1);

    drive_cycle(1'b1, 32'h0220C1B3, 1'b0, 1'b0, 1'b1, acc);
    check_eq("div_md", 64'(out_ctrl.md), 64'(M_EN));
    check_eq("div_mdop", 64'(out_ctrl.mdop), M_EN ? 64'd4 : 64'd0);
    check_eq("div_illegal", 64'(out_ctrl.illegal), 64'(!M_EN));
    stalls = 0; acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) begin
      drive_cycle(1'b1, 32'h00500093, 1'b0, 1'b0, 1'b1, acc);
      if (!acc) stalls++;
    end
    check_eq("div_addi_accepted", 64'(acc), 64'd1);
    check_eq("div_stall_cycles", 64'(stalls), M_EN ? 64'd3 : 64'd0);

    drive_cycle(1'b1, 32'h0220C1B3, 1'b0, 1'b0, 1'b1, acc);
    drive_cycle(1'b1, 32'h00500093, 1'b1, 1'b0, 1'b1, acc);
    check_eq("flush_div_busy", 64'(div_busy), 64'd0);
    check_eq("flush_out_valid", 64'(out_valid), 64'd0);

    drive_cycle(1'b1, 32'h00A00113, 1'b0, 1'b0, 1'b0, acc);
    for (int i = 0; i < 5; i++) begin
      drive_cycle(1'b1, $urandom, 1'b0, 1'b0, 1'b0, acc);
      check_eq("bp_in_ready", 64'(acc), 64'd0);
      check_eq("bp_out_ins", 64'(out_ins), 64'h00A00113);
    end
    drive_cycle(1'b1, 32'h00500093, 1'b0, 1'b1, 1'b1, acc);
    check_eq("hazard_drain", 64'(out_valid), 64'd0);

    drive_cycle(1'b1, 32'h0220C1B3, 1'b0, 1'b0, 1'b1, acc);
    drive_cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
    do_reset();

    for (int n = 0; n < 2000; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, gen_ins(), $urandom_range(0, 24) == 0,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, acc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
